// File: rtl/fetch_stage.sv
`default_nettype none
// ==========================================================================
// fetch_stage - PC owner, imem request/response, slot-reserving fetch queue
// Revision: 1.0
// ==========================================================================
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_instr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0]    c_last_ptr = PW'(DEPTH - 1);
    localparam logic [PW-1:0]    c_ptr_one  = PW'(1);
    localparam logic [CW-1:0]    c_cnt_one  = CW'(1);
    localparam logic [CW:0]      c_depth    = (CW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] c_step     = WIDTH'(4);

    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_q_pc     [DEPTH];
    logic [WIDTH-1:0] r_q_instr  [DEPTH];
    logic             r_q_filled [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW-1:0]    r_fill;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_unfilled;
    logic [CW-1:0]    r_drop;

    logic             w_accept;
    logic             w_pop;
    logic             w_rsp_fill;
    logic             w_rsp_drop;
    logic [CW:0]      w_used;
    logic [CW-1:0]    w_outstanding;
    logic [CW-1:0]    w_redirect_drop;
    logic             w_unused_bits;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_one;
    endfunction

    // Drained-but-not-yet-returned responses still occupy memory capacity,
    // so they count against the slot budget alongside reserved slots.
    assign w_used          = {1'b0, r_count} + {1'b0, r_drop};
    assign imem_req_valid  = !rst && (w_used < c_depth) && !redirect_valid;
    assign imem_req_addr   = r_fetch_pc;

    assign w_accept        = imem_req_valid && imem_req_ready;
    assign w_rsp_drop      = imem_rsp_valid && (r_drop != '0);
    assign w_rsp_fill      = imem_rsp_valid && (r_drop == '0) && (r_unfilled != '0);

    assign id_valid        = r_q_filled[r_head];
    assign id_pc           = r_q_pc[r_head];
    assign id_instr        = r_q_instr[r_head];
    assign w_pop           = id_valid && id_ready;

    assign w_outstanding   = r_drop + r_unfilled;
    assign w_redirect_drop = w_outstanding -
                             ((imem_rsp_valid && (w_outstanding != '0)) ? c_cnt_one : '0);
    assign w_unused_bits   = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]     <= '0;
                r_q_instr[i]  <= '0;
                r_q_filled[i] <= 1'b0;
            end
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00};
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_drop     <= w_redirect_drop;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_filled[i] <= 1'b0;
            end
        end else begin
            // Tail, fill and head slots are always distinct, so these
            // per-slot writes never collide.
            if (w_accept) begin
                r_q_pc[r_tail]     <= r_fetch_pc;
                r_q_filled[r_tail] <= 1'b0;
                r_tail             <= f_next(r_tail);
                r_fetch_pc         <= r_fetch_pc + c_step;
            end
            if (w_rsp_fill) begin
                r_q_instr[r_fill]  <= imem_rsp_data;
                r_q_filled[r_fill] <= 1'b1;
                r_fill             <= f_next(r_fill);
            end
            if (w_pop) begin
                r_q_filled[r_head] <= 1'b0;
                r_head             <= f_next(r_head);
            end
            if (w_rsp_drop) begin
                r_drop <= r_drop - c_cnt_one;
            end
            r_count    <= r_count + (w_accept ? c_cnt_one : '0) - (w_pop ? c_cnt_one : '0);
            r_unfilled <= r_unfilled + (w_accept ? c_cnt_one : '0) - (w_rsp_fill ? c_cnt_one : '0);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_rsp_expected: assert (!(imem_rsp_valid && (r_drop == '0) && (r_unfilled == '0)));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ==========================================================================
// tb_fetch_stage - directed bench for fetch_stage with a latency memory model
// Revision: 1.0
// ==========================================================================
module tb_fetch_stage;

    localparam int          W   = 32;
    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [W-1:0]  imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [W-1:0]  imem_rsp_data  = '0;
    logic          redirect_valid = 1'b0;
    logic [W-1:0]  redirect_pc    = '0;
    logic          id_valid;
    logic          id_ready       = 1'b0;
    logic [W-1:0]  id_pc;
    logic [W-1:0]  id_instr;

    fetch_stage #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_t;

    mem_t        mq[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          naccept = 0;
    int          npop  = 0;
    logic        tog   = 1'b0;
    logic        idr   = 1'b1;
    logic [31:0] exp_fa;
    logic [31:0] exp_pc;
    logic        obs_reqv;
    logic        obs_idv;
    logic [31:0] obs_pc;
    logic [31:0] obs_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic rdr, input logic [31:0] rpc);
        mem_t e;
        imem_req_ready = tog ? ((cyc % 2) == 0) : 1'b1;
        id_ready       = idr;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        obs_reqv = imem_req_valid;
        obs_idv  = id_valid;
        obs_pc   = id_pc;
        obs_addr = imem_req_addr;
        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            check_eq("req_addr", imem_req_addr, exp_fa);
            e.data = instr_of(imem_req_addr);
            e.due  = cyc + lat;
            mq.push_back(e);
            exp_fa = exp_fa + 32'd4;
            naccept++;
        end
        if (id_valid && id_ready) begin
            check_eq("id_pc", id_pc, exp_pc);
            check_eq("id_instr", id_instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            npop++;
        end
        if (rdr) begin
            check_eq("redir_reqv", {31'b0, imem_req_valid}, 32'd0);
            exp_fa = {rpc[31:2], 2'b00};
            exp_pc = exp_fa;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        mq.delete();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        cyc     = 0;
        exp_fa  = RPC;
        exp_pc  = RPC;
        naccept = 0;
        npop    = 0;
    endtask

    initial begin
        @(negedge clk);
        check_eq("rst_reqv", {31'b0, imem_req_valid}, 32'd0);
        check_eq("rst_idv", {31'b0, id_valid}, 32'd0);
        check_eq("rst_pc", id_pc, 32'd0);
        check_eq("rst_instr", id_instr, 32'd0);

        // First-instruction latency and full-queue gating, 1-cycle memory
        lat = 1; tog = 1'b0; idr = 1'b1;
        do_reset();
        step(1'b0, '0);
        check_eq("t1_c0_reqv", {31'b0, obs_reqv}, 32'd1);
        check_eq("t1_c0_idv", {31'b0, obs_idv}, 32'd0);
        step(1'b0, '0);
        check_eq("t1_c1_reqv", {31'b0, obs_reqv}, 32'd1);
        check_eq("t1_c1_idv", {31'b0, obs_idv}, 32'd0);
        step(1'b0, '0);
        check_eq("t1_c2_idv", {31'b0, obs_idv}, 32'd1);
        check_eq("t1_c2_pc", obs_pc, 32'd0);
        check_eq("t1_c2_reqv", {31'b0, obs_reqv}, 32'd0);
        repeat (10) step(1'b0, '0);
        check_eq("t1_pops", npop, 32'd8);

        // Decode stalled: only DEPTH requests go out
        idr = 1'b0;
        do_reset();
        repeat (6) step(1'b0, '0);
        check_eq("t2_accepts", naccept, 32'd2);
        check_eq("t2_reqv", {31'b0, obs_reqv}, 32'd0);
        check_eq("t2_idv", {31'b0, obs_idv}, 32'd1);
        check_eq("t2_pc", obs_pc, 32'd0);
        idr = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        check_eq("t2_pops", npop, 32'd2);
        check_eq("t2_resume", naccept, 32'd3);

        // Toggling ready with 3-cycle memory latency
        tog = 1'b1; lat = 3; idr = 1'b1;
        do_reset();
        repeat (40) step(1'b0, '0);
        check_eq("t3_progress", {31'b0, npop >= 10}, 32'd1);
        tog = 1'b0;

        // Redirect with two responses outstanding
        lat = 3; idr = 1'b0;
        do_reset();
        step(1'b0, '0);
        step(1'b0, '0);
        check_eq("t4_accepts", naccept, 32'd2);
        idr = 1'b1;
        step(1'b1, 32'h0000_0100);
        step(1'b0, '0);
        check_eq("t4_c3_reqv", {31'b0, obs_reqv}, 32'd0);
        step(1'b0, '0);
        check_eq("t4_c4_reqv", {31'b0, obs_reqv}, 32'd1);
        check_eq("t4_c4_addr", obs_addr, 32'h0000_0100);
        repeat (8) step(1'b0, '0);
        check_eq("t4_pops", npop, 32'd2);

        // Misaligned redirect coinciding with a pop and a response
        lat = 1; idr = 1'b1;
        do_reset();
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, 32'h0000_0203);
        check_eq("t5_pop_idv", {31'b0, obs_idv}, 32'd1);
        check_eq("t5_pop_pc", obs_pc, 32'd0);
        step(1'b0, '0);
        check_eq("t5_reqv", {31'b0, obs_reqv}, 32'd1);
        check_eq("t5_addr", obs_addr, 32'h0000_0200);
        repeat (6) step(1'b0, '0);
        check_eq("t5_pops", npop, 32'd5);

        // Asynchronous reset with fetches in flight
        lat = 2; idr = 1'b0;
        do_reset();
        repeat (3) step(1'b0, '0);
        step(1'b0, '0);
        check_eq("t6_pre_idv", {31'b0, obs_idv}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_async_idv", {31'b0, id_valid}, 32'd0);
        check_eq("t6_async_reqv", {31'b0, imem_req_valid}, 32'd0);
        check_eq("t6_async_pc", id_pc, 32'd0);
        @(negedge clk);
        idr = 1'b1;
        do_reset();
        step(1'b0, '0);
        check_eq("t6_restart_reqv", {31'b0, obs_reqv}, 32'd1);
        check_eq("t6_restart_addr", obs_addr, RPC);
        repeat (4) step(1'b0, '0);
        check_eq("t6_pops", {31'b0, npop >= 2}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
